pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit simple core.
- Drives the program-counter block's EN/INC/TARGET controls and the instruction-memory request handshake.
- Latches the fetched instruction and emits a one-cycle execute strobe for the datapath.
- Handles branch redirection, stalls, halt/resume and a retired-instruction counter.

Parameters:
- WIDTH, 6, PC / branch-target width (matches the PC block).
- IWIDTH, 8, instruction word width.
- CWIDTH, 16, retired-instruction counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- RUN  in  1  start/resume request (level; resume from HALT is edge-detected).
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ACK  in  1  fetch data valid; sampled only in FETCH.
- IMEM_RDATA  in  IWIDTH  fetched instruction.
- IR  out  IWIDTH  instruction register.
- HALT_INSN  in  1  decode flag, valid in DECODE: IR is a halt.
- BR_TAKEN  in  1  branch-taken flag, valid in EXEC.
- BR_TARGET  in  WIDTH  branch target, valid in EXEC.
- STALL  in  1  datapath stall; holds EXEC.
- PC_EN  out  1  PC update enable.
- PC_INC  out  1  1 = PC+1, 0 = load PC_TARGET.
- PC_TARGET  out  WIDTH  PC load value.
- EXEC  out  1  one-cycle execute strobe per instruction.
- HALTED  out  1  core halted.
- RETIRED  out  CWIDTH  count of executed instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT. State, IR, RETIRED and RUN_q are registered; all other outputs are decoded combinationally from state plus inputs.
- Reset (RST=1 at an edge), from any state:
  - state=IDLE, IR=0, RETIRED=0, RUN_q=0.
  - Outputs while reset/IDLE: IMEM_REQ=0, PC_EN=0, PC_INC=1, PC_TARGET=0, EXEC=0, HALTED=0.
  - Reset mid-fetch: IMEM_REQ drops after the reset edge; a late ACK is ignored.
- IDLE: RUN=1 → FETCH. Otherwise stay.
- FETCH:
  - IMEM_REQ=1, held until IMEM_ACK=1.
  - On ACK: IR<=IMEM_RDATA, → DECODE. IMEM_REQ is 0 in the following cycle.
  - ACK in any other state is ignored, and IR is not written.
- DECODE: always one cycle.
  - HALT_INSN=1 → HALT. PC is not updated, so PC still points at the halt instruction.
  - Otherwise → EXEC.
- EXEC:
  - STALL=1: EXEC=0, PC_EN=0, stay in EXEC.
  - STALL=0:
    - EXEC=1 and PC_EN=1 for exactly this cycle.
    - PC_INC=~BR_TAKEN; PC_TARGET=BR_TARGET, forced to 0 when PC_INC=1.
    - RETIRED<=RETIRED+1, wrapping modulo 2^CWIDTH.
    - Next state: FETCH if RUN=1, IDLE if RUN=0. The instruction always completes before dropping to IDLE.
  - A branch to the current PC is legal and behaves as any other branch.
- HALT:
  - HALTED=1; PC_EN=0; RUN_q<=RUN every cycle.
  - Resume on a RUN rising edge (RUN=1 and RUN_q=0): PC_EN=1, PC_INC=1 for that one cycle (steps past the halt), → FETCH. Halt is not counted in RETIRED.
  - RUN held high through entry to HALT does not resume; RUN must drop and rise.
  - RUN_q is loaded with RUN on entry to HALT.
- Latency: with ACK on the first FETCH cycle and no stall, one instruction takes 3 cycles (FETCH, DECODE, EXEC). Each cycle of ACK delay or STALL adds one cycle.
- Simultaneous events:
  - STALL and BR_TAKEN together: stall wins; the branch is sampled on the first unstalled EXEC cycle.
  - RST overrides all inputs.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/FETCH/DECODE/EXEC/HALT, 3-bit encoding);
  - default parameter constants PC_WIDTH=6, INSN_WIDTH=8, RETIRE_WIDTH=16.
- One natural sub-module: rise_detect (a RUN_q register plus AND), reused elsewhere for front-panel buttons.
- The FSM and output decode stay in pc_sequencer.

Test Plan:
- Reset then RUN=1, ACK same cycle as REQ, no branches, three fetches → cycles 1/2/3 = FETCH/DECODE/EXEC; PC_EN=1 with PC_INC=1 every 3rd cycle; RETIRED=3; IR matches each RDATA.
- ACK delayed 4 cycles → IMEM_REQ high for exactly 5 cycles; IR changes only on the ACK cycle; an ACK pulse during DECODE is ignored.
- BR_TAKEN=1, BR_TARGET=6'h2A in EXEC → PC_EN=1, PC_INC=0, PC_TARGET=2A for one cycle; no branch with BR_TARGET=2A → PC_TARGET=0, PC_INC=1.
- STALL=1 for 3 cycles in EXEC with BR_TAKEN=1 → EXEC/PC_EN low 3 cycles, then a single pulse loading the target; RETIRED increments once.
- HALT_INSN=1 in DECODE with RUN held high → HALTED=1 and no PC_EN; RUN 1→0→1 → one-cycle PC_EN with PC_INC=1, then FETCH; RETIRED unchanged by the halt.
- RST pulsed mid-FETCH with ACK arriving next cycle → IDLE, IR=0, RETIRED=0, IMEM_REQ=0, the ACK is ignored; RETIRED preset near 16'hFFFF wraps to 0 after 16'hFFFF.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared state encoding and default widths for the instruction
//               sequencer of the 8-bit simple core.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  // Default widths, matching the PC block and the instruction memory
  localparam int PC_WIDTH     = 6;
  localparam int INSN_WIDTH   = 8;
  localparam int RETIRE_WIDTH = 16;

  // Sequencer state encoding (3-bit)
  typedef logic [2:0] seq_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Registers a level input and flags a 0->1 transition in the
//               cycle the new level is seen. Also used for front-panel buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Previous-cycle copy of the input level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC sequencer. Drives the PC block
//               controls and the instruction-memory handshake, holds the IR,
//               handles branches, stalls, halt/resume and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH  = PC_WIDTH,
  parameter int IWIDTH = INSN_WIDTH,
  parameter int CWIDTH = RETIRE_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  output logic              imem_req_o,
  input  logic              imem_ack_i,
  input  logic [IWIDTH-1:0] imem_rdata_i,
  output logic [IWIDTH-1:0] ir_o,
  input  logic              halt_insn_i,
  input  logic              br_taken_i,
  input  logic [WIDTH-1:0]  br_target_i,
  input  logic              stall_i,
  output logic              pc_en_o,
  output logic              pc_inc_o,
  output logic [WIDTH-1:0]  pc_target_o,
  output logic              exec_o,
  output logic              halted_o,
  output logic [CWIDTH-1:0] retired_o
);

  seq_state_t        state_q, state_d;
  logic [IWIDTH-1:0] ir_q;
  logic [CWIDTH-1:0] retired_q;
  logic              w_run_rise;
  logic              w_exec_fire;
  logic              w_resume;

  // RUN history runs every cycle, so on entry to HALT it already holds the
  // RUN level seen in DECODE; a level held high through the halt never resumes.
  rise_detect u_run_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (run_i),
    .rise_o (w_run_rise)
  );

  // An unstalled EXEC cycle retires the instruction; stall masks the branch.
  assign w_exec_fire = (state_q == ST_EXEC) && !stall_i;
  assign w_resume    = (state_q == ST_HALT) && w_run_rise;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run_i)        state_d = ST_FETCH;
      ST_FETCH:  if (imem_ack_i)   state_d = ST_DECODE;
      ST_DECODE: state_d = halt_insn_i ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (!stall_i)     state_d = run_i ? ST_FETCH : ST_IDLE;
      ST_HALT:   if (w_run_rise)   state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, instruction register and retirement counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_FETCH) && imem_ack_i) begin
        ir_q <= imem_rdata_i;
      end
      if (w_exec_fire) begin
        retired_q <= retired_q + CWIDTH'(1);
      end
    end
  end

  // Output decode. Resume from HALT steps the PC past the halt instruction.
  assign imem_req_o  = (state_q == ST_FETCH);
  assign exec_o      = w_exec_fire;
  assign halted_o    = (state_q == ST_HALT);
  assign pc_en_o     = w_exec_fire || w_resume;
  assign pc_inc_o    = w_exec_fire ? !br_taken_i : 1'b1;
  assign pc_target_o = (w_exec_fire && br_taken_i) ? br_target_i : '0;
  assign ir_o        = ir_q;
  assign retired_o   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. A second
//               instance with a 3-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, ack, halt, br, stall;
  logic [7:0] rdata;
  logic [5:0] tgt;

  logic        req, pc_en, pc_inc, exec, halted;
  logic [7:0]  ir;
  logic [5:0]  pc_tgt;
  logic [15:0] retired;

  logic        s_req, s_pc_en, s_pc_inc, s_exec, s_halted;
  logic [7:0]  s_ir;
  logic [5:0]  s_pc_tgt;
  logic [2:0]  s_retired;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ret;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(6), .IWIDTH(8), .CWIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .imem_req_o(req), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .ir_o(ir), .halt_insn_i(halt), .br_taken_i(br),
    .br_target_i(tgt), .stall_i(stall), .pc_en_o(pc_en), .pc_inc_o(pc_inc),
    .pc_target_o(pc_tgt), .exec_o(exec), .halted_o(halted), .retired_o(retired)
  );

  pc_sequencer #(.WIDTH(6), .IWIDTH(8), .CWIDTH(3)) dut_s (
    .clk_i(clk), .rst_i(rst), .run_i(run), .imem_req_o(s_req), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .ir_o(s_ir), .halt_insn_i(halt), .br_taken_i(br),
    .br_target_i(tgt), .stall_i(stall), .pc_en_o(s_pc_en), .pc_inc_o(s_pc_inc),
    .pc_target_o(s_pc_tgt), .exec_o(s_exec), .halted_o(s_halted), .retired_o(s_retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, raise RUN, and leave them in their first FETCH cycle
  task automatic start_fetch();
    rst = 1'b1; run = 1'b0; ack = 1'b0; halt = 1'b0; br = 1'b0;
    stall = 1'b0; tgt = '0; rdata = '0;
    tick(); tick();
    rst = 1'b0; run = 1'b1;
    tick();
    exp_ret = '0;
  endtask

  // One plain instruction from FETCH back to FETCH (ACK at once, no stall)
  task automatic run_insn(input logic [7:0] d);
    ack = 1'b1; rdata = d; tick();
    ack = 1'b0; rdata = '0; tick();
    tick();
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; ack = 1'b0; halt = 1'b0; br = 1'b0;
    stall = 1'b0; tgt = '0; rdata = '0;
    tick(); tick();
    checks++;
    if ({req, pc_en, pc_inc, pc_tgt, exec, halted} !== {1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b en=%b inc=%b tgt=%h exec=%b halted=%b, expected 0 0 1 00 0 0",
               req, pc_en, pc_inc, pc_tgt, exec, halted);
    end
    checks++;
    if ({ir, retired} !== 24'h0) begin
      errors++;
      $display("FAIL reset_regs: got ir=%h retired=%h, expected 00 0000", ir, retired);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_run: got req=%b, expected 0", req);
    end
  endtask

  task automatic test_basic();
    logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
    start_fetch();
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; rdata = data[k]; #1;
      checks++;
      if ({req, exec, pc_en} !== 3'b100) begin
        errors++;
        $display("FAIL basic_fetch%0d: got req/exec/en=%b%b%b, expected 100", k, req, exec, pc_en);
      end
      tick();
      ack = 1'b0; rdata = '0; #1;
      checks++;
      if ({ir, req, exec, pc_en} !== {data[k], 3'b000}) begin
        errors++;
        $display("FAIL basic_decode%0d: got ir=%h req/exec/en=%b%b%b, expected ir=%h 000",
                 k, ir, req, exec, pc_en, data[k]);
      end
      tick();
      checks++;
      if ({exec, pc_en, pc_inc, pc_tgt} !== {3'b111, 6'h00}) begin
        errors++;
        $display("FAIL basic_exec%0d: got exec=%b en=%b inc=%b tgt=%h, expected 1 1 1 00",
                 k, exec, pc_en, pc_inc, pc_tgt);
      end
      tick();
      exp_ret = exp_ret + 16'd1;
    end
    checks++;
    if (retired !== 16'd3) begin
      errors++;
      $display("FAIL basic_retired: got %0d, expected 3", retired);
    end
  endtask

  task automatic test_ack_delay();
    int req_cycles = 0;
    start_fetch();
    for (int i = 0; i < 4; i++) begin
      ack = 1'b0; rdata = 8'hC3; #1;
      if (req === 1'b1) req_cycles++;
      tick();
      checks++;
      if (ir !== 8'h00) begin
        errors++;
        $display("FAIL ackdly_ir_hold%0d: got ir=%h, expected 00", i, ir);
      end
    end
    ack = 1'b1; rdata = 8'h5A; #1;
    if (req === 1'b1) req_cycles++;
    tick();
    checks++;
    if (ir !== 8'h5A) begin
      errors++;
      $display("FAIL ackdly_ir_load: got ir=%h, expected 5a", ir);
    end
    ack = 1'b1; rdata = 8'hFF; #1;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL ackdly_req_drop: got req=%b, expected 0", req);
    end
    checks++;
    if (req_cycles !== 5) begin
      errors++;
      $display("FAIL ackdly_req_cycles: got %0d, expected 5", req_cycles);
    end
    tick();
    ack = 1'b0;
    #1;
    checks++;
    if ({ir, exec} !== {8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL ackdly_decode_ack_ignored: got ir=%h exec=%b, expected 5a 1", ir, exec);
    end
    tick();
  endtask

  task automatic test_branch();
    start_fetch();
    ack = 1'b1; rdata = 8'h40; tick();
    ack = 1'b0; tick();
    br = 1'b1; tgt = 6'h2A; #1;
    checks++;
    if ({exec, pc_en, pc_inc, pc_tgt} !== {3'b110, 6'h2A}) begin
      errors++;
      $display("FAIL branch_taken: got exec=%b en=%b inc=%b tgt=%h, expected 1 1 0 2a",
               exec, pc_en, pc_inc, pc_tgt);
    end
    tick();
    checks++;
    if ({pc_en, pc_inc, pc_tgt} !== {2'b01, 6'h00}) begin
      errors++;
      $display("FAIL branch_one_cycle: got en=%b inc=%b tgt=%h, expected 0 1 00", pc_en, pc_inc, pc_tgt);
    end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    br = 1'b0; tgt = 6'h2A; #1;
    checks++;
    if ({exec, pc_en, pc_inc, pc_tgt} !== {3'b111, 6'h00}) begin
      errors++;
      $display("FAIL branch_not_taken: got exec=%b en=%b inc=%b tgt=%h, expected 1 1 1 00",
               exec, pc_en, pc_inc, pc_tgt);
    end
    tick();
    tgt = '0;
  endtask

  task automatic test_stall();
    start_fetch();
    ack = 1'b1; rdata = 8'h77; tick();
    ack = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; br = 1'b1; tgt = 6'h15; #1;
      checks++;
      if ({exec, pc_en, retired} !== {2'b00, 16'd0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got exec=%b en=%b retired=%0d, expected 0 0 0",
                 i, exec, pc_en, retired);
      end
      tick();
    end
    stall = 1'b0; #1;
    checks++;
    if ({exec, pc_en, pc_inc, pc_tgt} !== {3'b110, 6'h15}) begin
      errors++;
      $display("FAIL stall_release: got exec=%b en=%b inc=%b tgt=%h, expected 1 1 0 15",
               exec, pc_en, pc_inc, pc_tgt);
    end
    tick();
    br = 1'b0; tgt = '0; #1;
    checks++;
    if ({exec, retired} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL stall_retired: got exec=%b retired=%0d, expected 0 1", exec, retired);
    end
  endtask

  task automatic test_halt();
    start_fetch();
    ack = 1'b1; rdata = 8'hF0; tick();
    ack = 1'b0; halt = 1'b1; #1;
    checks++;
    if (pc_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_decode_en: got en=%b, expected 0", pc_en);
    end
    tick();
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({halted, pc_en} !== 2'b10) begin
        errors++;
        $display("FAIL halt_run_held%0d: got halted=%b en=%b, expected 1 0", i, halted, pc_en);
      end
      tick();
    end
    run = 1'b0; tick();
    run = 1'b1; #1;
    checks++;
    if ({halted, pc_en, pc_inc, pc_tgt, exec} !== {3'b111, 6'h00, 1'b0}) begin
      errors++;
      $display("FAIL halt_resume: got halted=%b en=%b inc=%b tgt=%h exec=%b, expected 1 1 1 00 0",
               halted, pc_en, pc_inc, pc_tgt, exec);
    end
    tick();
    checks++;
    if ({halted, req, pc_en, retired} !== {3'b010, 16'd0}) begin
      errors++;
      $display("FAIL halt_to_fetch: got halted=%b req=%b en=%b retired=%0d, expected 0 1 0 0",
               halted, req, pc_en, retired);
    end
  endtask

  task automatic test_run_drop();
    start_fetch();
    ack = 1'b1; rdata = 8'h09; tick();
    ack = 1'b0; tick();
    run = 1'b0; #1;
    checks++;
    if (exec !== 1'b1) begin
      errors++;
      $display("FAIL rundrop_exec_completes: got exec=%b, expected 1", exec);
    end
    tick(); tick();
    checks++;
    if ({req, exec, retired} !== {2'b00, 16'd1}) begin
      errors++;
      $display("FAIL rundrop_idle: got req=%b exec=%b retired=%0d, expected 0 0 1", req, exec, retired);
    end
    run = 1'b1; tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL rundrop_restart: got req=%b, expected 1", req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    start_fetch();
    run_insn(8'hA5);
    rst = 1'b1; tick();
    rst = 1'b0; run = 1'b0; ack = 1'b1; rdata = 8'hEE; #1;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL rstfetch_req: got req=%b, expected 0", req);
    end
    tick();
    ack = 1'b0; #1;
    checks++;
    if ({ir, retired, req} !== {8'h00, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstfetch_late_ack: got ir=%h retired=%0d req=%b, expected 00 0 0", ir, retired, req);
    end
  endtask

  task automatic test_wrap();
    start_fetch();
    for (int i = 0; i < 7; i++) run_insn(8'(i + 1));
    checks++;
    if (s_retired !== 3'd7) begin
      errors++;
      $display("FAIL wrap_at_max: got %0d, expected 7", s_retired);
    end
    run_insn(8'h08);
    checks++;
    if ({s_retired, retired} !== {3'd0, 16'd8}) begin
      errors++;
      $display("FAIL wrap_to_zero: got small=%0d full=%0d, expected 0 8", s_retired, retired);
    end
    run_insn(8'h09);
    checks++;
    if (s_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL wrap_after: got %0d, expected %0d", s_retired, exp_ret[2:0]);
    end
  endtask

  initial begin
    exp_ret = '0;
    test_reset();
    test_basic();
    test_ack_delay();
    test_branch();
    test_stall();
    test_halt();
    test_run_drop();
    test_reset_mid_fetch();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
